// File: rtl/turn_pkg.sv
// Shared state encoding, width helpers and default sizing for the turn timer controller.
package turn_pkg;

  localparam int DEF_NUM_PLAYERS  = 2;
  localparam int DEF_MAX_TURNS    = 9;
  localparam int DEF_MAX_TIMEOUTS = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PLAY    = 3'd2,
    S_TIMEOUT = 3'd3,
    S_COMMIT  = 3'd4,
    S_DONE    = 3'd5
  } turn_state_t;

  // Player index width, never narrower than one bit.
  function automatic int player_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Width needed to hold the values 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/turn_timer_controller_if.sv
// Board/timer-facing signal bundle of the turn timer controller.
// TURN_TIMER_PAUSE_EN adds the pause input.
interface turn_timer_if #(
  parameter int PW = 1,
  parameter int TW = 4
);
`ifdef TURN_TIMER_PAUSE_EN
  logic          pause;
`endif
  logic          start;
  logic          t0;
  logic          move_valid;
  logic          move_legal;
  logic          win_detect;
  logic          auto_move_ack;
  logic          move_ready;
  logic          timer_enable;
  logic          timer_reload;
  logic          auto_move_req;
  logic [PW-1:0] current_player;
  logic [TW-1:0] turn_count;
  logic          game_over;
  logic [PW-1:0] winner;
  logic          draw;

  // master: board logic and timer side; slave: the controller.
  modport master (
`ifdef TURN_TIMER_PAUSE_EN
    output pause,
`endif
    output start, t0, move_valid, move_legal, win_detect, auto_move_ack,
    input  move_ready, timer_enable, timer_reload, auto_move_req,
    input  current_player, turn_count, game_over, winner, draw
  );

  modport slave (
`ifdef TURN_TIMER_PAUSE_EN
    input  pause,
`endif
    input  start, t0, move_valid, move_legal, win_detect, auto_move_ack,
    output move_ready, timer_enable, timer_reload, auto_move_req,
    output current_player, turn_count, game_over, winner, draw
  );
endinterface

// File: rtl/nbit_counter.sv
// Generic W-bit up counter with synchronous clear (clear wins over enable).
module nbit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= q + W'(1);
  end
endmodule

// File: rtl/turn_timer_controller_strike_counter.sv
// Per-player saturating timeout counter; term is high once MAX strikes are reached.
module strike_counter
  import turn_pkg::*;
#(
  parameter int MAX = DEF_MAX_TIMEOUTS
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic term
);
  localparam int SW = count_width(MAX);

  logic [SW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         cnt <= '0;
    else if (clr)                      cnt <= '0;
    else if (inc && cnt != SW'(MAX))   cnt <= cnt + SW'(1);
  end

  assign term = (cnt == SW'(MAX));
endmodule

// File: rtl/turn_timer_controller.sv
// Game-turn sequencer driving the countdown timer and forcing moves on timeout.
// TURN_TIMER_PAUSE_EN adds a pause input that freezes the PLAY state.
module turn_timer_controller
  import turn_pkg::*;
#(
  parameter int NUM_PLAYERS  = DEF_NUM_PLAYERS,
  parameter int MAX_TURNS    = DEF_MAX_TURNS,
  parameter int MAX_TIMEOUTS = DEF_MAX_TIMEOUTS
) (
  input logic         clk,
  input logic         reset,
  turn_timer_if.slave bus
);
  localparam int PW = player_width(NUM_PLAYERS);
  localparam int TW = count_width(MAX_TURNS);

  turn_state_t          state, state_nxt;
  logic [PW-1:0]        current_player, next_player, winner_q;
  logic [TW-1:0]        turn_count;
  logic                 draw_q;
  logic                 mask_q;
  logic                 paused;
  logic [NUM_PLAYERS-1:0] strike_term;
  logic                 start_game, clr_cur, inc_cur, turn_inc;
  logic                 win_cur, win_next, set_draw, adv_player;
  logic                 cur_term;

`ifdef TURN_TIMER_PAUSE_EN
  assign paused = bus.pause;
`else
  assign paused = 1'b0;
`endif

  assign next_player = (current_player == PW'(NUM_PLAYERS - 1)) ? '0
                                                                : current_player + PW'(1);
  assign cur_term    = strike_term[current_player];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_game = 1'b0;
    clr_cur    = 1'b0;
    inc_cur    = 1'b0;
    turn_inc   = 1'b0;
    win_cur    = 1'b0;
    win_next   = 1'b0;
    set_draw   = 1'b0;
    adv_player = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          start_game = 1'b1;
          state_nxt  = S_LOAD;
        end
      end
      S_LOAD: state_nxt = S_PLAY;
      S_PLAY: begin
        if (!paused) begin
          if (bus.move_valid && bus.move_legal) begin
            clr_cur   = 1'b1;
            state_nxt = S_COMMIT;
          end else if (bus.t0 && !mask_q) begin
            inc_cur   = 1'b1;
            state_nxt = S_TIMEOUT;
          end
        end
      end
      S_TIMEOUT: begin
        // The strike was already counted on entry, so term reflects the new count.
        if (cur_term) begin
          win_next  = 1'b1;
          state_nxt = S_DONE;
        end else if (bus.auto_move_ack) begin
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        turn_inc = 1'b1;
        if (bus.win_detect) begin
          win_cur   = 1'b1;
          state_nxt = S_DONE;
        end else if (turn_count == TW'(MAX_TURNS - 1)) begin
          set_draw  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          adv_player = 1'b1;
          state_nxt  = S_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // t0 is ignored for one PLAY cycle after a reload or after pause is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask_q <= 1'b0;
    else       mask_q <= (state == S_LOAD) || (state == S_PLAY && paused);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      current_player <= '0;
      winner_q       <= '0;
      draw_q         <= 1'b0;
    end else begin
      if (start_game)      current_player <= '0;
      else if (adv_player) current_player <= next_player;

      if (start_game)    winner_q <= '0;
      else if (win_cur)  winner_q <= current_player;
      else if (win_next) winner_q <= next_player;

      if (start_game)    draw_q <= 1'b0;
      else if (set_draw) draw_q <= 1'b1;
    end
  end

  nbit_counter #(.W(TW)) u_turn_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_game),
    .en    (turn_inc),
    .q     (turn_count)
  );

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_strike
    strike_counter #(.MAX(MAX_TIMEOUTS)) u_strike (
      .clk   (clk),
      .reset (reset),
      .clr   (start_game || (clr_cur && current_player == PW'(p))),
      .inc   (inc_cur && current_player == PW'(p)),
      .term  (strike_term[p])
    );
  end

  assign bus.move_ready     = (state == S_PLAY) && !paused;
  assign bus.timer_enable   = (state == S_PLAY) && !paused;
  assign bus.timer_reload   = (state == S_LOAD);
  assign bus.auto_move_req  = (state == S_TIMEOUT) && !cur_term;
  assign bus.game_over      = (state == S_DONE);
  assign bus.current_player = current_player;
  assign bus.turn_count     = turn_count;
  assign bus.winner         = winner_q;
  assign bus.draw           = draw_q;

endmodule

// File: tb/tb_turn_timer_controller.sv
// Directed bench for turn_timer_controller: vector table plus multi-cycle sequences.
module tb_turn_timer_controller;
  import turn_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  turn_timer_if #(.PW(1), .TW(4)) bus ();

  turn_timer_controller #(
    .NUM_PLAYERS  (2),
    .MAX_TURNS    (9),
    .MAX_TIMEOUTS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int start, t0, mv, ml, win, ack;
    int ready, en, reload, req, player, turns, over, winner, draw;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.t0 = 1'b0; bus.move_valid = 1'b0;
    bus.move_legal = 1'b0; bus.win_detect = 1'b0; bus.auto_move_ack = 1'b0;
  endtask

  task automatic wait_play();
    for (int k = 0; k < 10; k++) begin
      if (bus.move_ready) break;
      cycle();
    end
    check("wait_play", int'(bus.move_ready), 1);
  endtask

  task automatic do_move(input logic win);
    wait_play();
    bus.move_valid = 1'b1; bus.move_legal = 1'b1;
    cycle();
    bus.move_valid = 1'b0; bus.move_legal = 1'b0;
    bus.win_detect = win;
    cycle();
    bus.win_detect = 1'b0;
  endtask

  // Lets the timer expire; acks d cycles after TIMEOUT entry, returns req-high cycle count.
  task automatic do_timeout(input int d, output int n);
    wait_play();
    cycle();
    bus.t0 = 1'b1;
    cycle();
    bus.t0 = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.auto_move_req) break;
      n++;
      bus.auto_move_ack = (k == d);
      cycle();
      bus.auto_move_ack = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".ready"},  int'(bus.move_ready), 0);
    check({tag, ".en"},     int'(bus.timer_enable), 0);
    check({tag, ".reload"}, int'(bus.timer_reload), 0);
    check({tag, ".req"},    int'(bus.auto_move_req), 0);
    check({tag, ".player"}, int'(bus.current_player), 0);
    check({tag, ".turns"},  int'(bus.turn_count), 0);
    check({tag, ".over"},   int'(bus.game_over), 0);
    check({tag, ".winner"}, int'(bus.winner), 0);
    check({tag, ".draw"},   int'(bus.draw), 0);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
`ifdef TURN_TIMER_PAUSE_EN
    bus.pause = 1'b0;
`endif
    reset = 1'b1;

    //           start t0 mv ml win ack | rdy en rld req ply trn ovr win drw
    vecs[0]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0}; // IDLE, start
    vecs[1]  = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0}; // LOAD
    vecs[2]  = '{0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0}; // PLAY, masked t0
    vecs[3]  = '{1, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0}; // illegal move, start ignored
    vecs[4]  = '{0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0}; // legal move
    vecs[5]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0}; // COMMIT
    vecs[6]  = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 1, 0, 0, 0}; // LOAD p1
    vecs[7]  = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 1, 0, 0, 0}; // PLAY mask
    vecs[8]  = '{0, 1, 1, 1, 0, 0,  1, 1, 0, 0, 1, 1, 0, 0, 0}; // t0 + move
    vecs[9]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 0, 0}; // COMMIT, no req
    vecs[10] = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 2, 0, 0, 0}; // LOAD p0
    vecs[11] = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2, 0, 0, 0}; // PLAY mask
    vecs[12] = '{0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2, 0, 0, 0}; // t0 expires
    vecs[13] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2, 0, 0, 0}; // TIMEOUT entry
    vecs[14] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2, 0, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2, 0, 0, 0};
    vecs[16] = '{0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 2, 0, 0, 0}; // ack
    vecs[17] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 0, 0, 0}; // COMMIT
    vecs[18] = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 3, 0, 0, 0}; // LOAD p1

    cycle();
    cycle();
    check_outputs_zero("por");
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      bus.start         = vecs[i].start[0];
      bus.t0            = vecs[i].t0[0];
      bus.move_valid    = vecs[i].mv[0];
      bus.move_legal    = vecs[i].ml[0];
      bus.win_detect    = vecs[i].win[0];
      bus.auto_move_ack = vecs[i].ack[0];
      check($sformatf("v%0d.ready", i),  int'(bus.move_ready),     vecs[i].ready);
      check($sformatf("v%0d.en", i),     int'(bus.timer_enable),   vecs[i].en);
      check($sformatf("v%0d.reload", i), int'(bus.timer_reload),   vecs[i].reload);
      check($sformatf("v%0d.req", i),    int'(bus.auto_move_req),  vecs[i].req);
      check($sformatf("v%0d.player", i), int'(bus.current_player), vecs[i].player);
      check($sformatf("v%0d.turns", i),  int'(bus.turn_count),     vecs[i].turns);
      check($sformatf("v%0d.over", i),   int'(bus.game_over),      vecs[i].over);
      check($sformatf("v%0d.winner", i), int'(bus.winner),         vecs[i].winner);
      check($sformatf("v%0d.draw", i),   int'(bus.draw),           vecs[i].draw);
      cycle();
    end
    clear_inputs();

    // Reset in the middle of player 1's PLAY, then restart.
    check("midplay.ready",  int'(bus.move_ready), 1);
    check("midplay.player", int'(bus.current_player), 1);
    check("midplay.turns",  int'(bus.turn_count), 3);
    reset = 1'b1;
    #1;
    check_outputs_zero("rst");
    #1;
    reset = 1'b0;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    check("restart.reload", int'(bus.timer_reload), 1);
    check("restart.player", int'(bus.current_player), 0);
    cycle();
    check("restart.reload_pulse", int'(bus.timer_reload), 0);

    // Three consecutive timeouts by player 0 forfeit the game.
    do_timeout(3, n);
    check("to1.req_cycles", n, 4);
    cycle();
    check("to1.turns",  int'(bus.turn_count), 1);
    check("to1.player", int'(bus.current_player), 1);
    do_move(1'b0);
    do_timeout(0, n);
    check("to2.req_cycles", n, 1);
    do_move(1'b0);
    do_timeout(0, n);
    check("to3.req_cycles", n, 0);
    cycle();
    check("forfeit.over",   int'(bus.game_over), 1);
    check("forfeit.winner", int'(bus.winner), 1);
    check("forfeit.draw",   int'(bus.draw), 0);
    check("forfeit.turns",  int'(bus.turn_count), 4);
    check("forfeit.en",     int'(bus.timer_enable), 0);
    cycle();
    check("forfeit.frozen", int'(bus.game_over), 1);

    // Nine commits without a win end in a draw.
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    check("draw.restart_turns", int'(bus.turn_count), 0);
    for (int m = 0; m < 9; m++) do_move(1'b0);
    check("draw.over",   int'(bus.game_over), 1);
    check("draw.draw",   int'(bus.draw), 1);
    check("draw.turns",  int'(bus.turn_count), 9);
    check("draw.player", int'(bus.current_player), 0);

    // Win reported on the fifth commit.
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int m = 0; m < 4; m++) do_move(1'b0);
    do_move(1'b1);
    check("win.over",   int'(bus.game_over), 1);
    check("win.winner", int'(bus.winner), 0);
    check("win.draw",   int'(bus.draw), 0);
    check("win.turns",  int'(bus.turn_count), 5);

    // An accepted move clears the mover's strikes.
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    do_timeout(0, n);
    do_move(1'b0);
    do_timeout(0, n);
    do_move(1'b0);
    do_move(1'b0);
    do_move(1'b0);
    do_timeout(0, n);
    check("strike_clear.req_cycles", n, 1);
    check("strike_clear.over", int'(bus.game_over), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
